// File: rtl/mips_pkg.sv
// Shared defaults and loader state encoding for the instruction-memory loader.
package mips_pkg;

  localparam int          ADDR_W_DEF    = 8;
  localparam logic [31:0] HALT_WORD_DEF = 32'hFFFF_FFFF;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RECV  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/word_assembler.sv
// Big-endian byte-to-word assembler: first byte lands in bits [31:24].
module word_assembler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic [31:0] word,
  output logic        word_ready
);

  logic [1:0] byte_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      word     <= '0;
      byte_cnt <= '0;
    end else if (en && rx_valid) begin
      word     <= {word[23:0], rx_data};
      byte_cnt <= byte_cnt + 2'd1;
    end
  end

  // Pulses with the capture of the 4th byte; the counter wraps so the next
  // accepted byte (even one arriving during the write cycle) is byte 0.
  assign word_ready = en && rx_valid && (byte_cnt == 2'd3);

endmodule

// File: rtl/instr_mem_loader.sv
// Loads a program received byte-wise into instruction memory, then hands the
// memory address port back to the fetch PC.
module instr_mem_loader
  import mips_pkg::*;
#(
  parameter int          ADDR_W    = ADDR_W_DEF,
  parameter logic [31:0] HALT_WORD = HALT_WORD_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_valid,
  input  logic [31:0]       i_pc,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_data,
  output logic              o_mem_we,
  output logic              o_mem_ce,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_overflow,
  output logic              o_misaligned,
  output logic [ADDR_W:0]   o_word_count
);

  logic [1:0]        state;
  logic [ADDR_W-1:0] ptr;
  logic              start_ok;
  logic              accept_en;
  logic              word_ready;
  logic [31:0]       word;
  logic              unused_pc_hi;

  assign start_ok  = i_start && (state == ST_IDLE || state == ST_DONE);
  assign accept_en = (state == ST_RECV) || (state == ST_WRITE);

  word_assembler u_asm (
    .clk        (i_clk),
    .rst_n      (i_rst_n),
    .clear      (start_ok),
    .en         (accept_en),
    .rx_valid   (i_rx_valid),
    .rx_data    (i_rx_data),
    .word       (word),
    .word_ready (word_ready)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state        <= ST_IDLE;
      ptr          <= '0;
      o_word_count <= '0;
      o_done       <= 1'b0;
      o_overflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state        <= ST_RECV;
            ptr          <= '0;
            o_word_count <= '0;
            o_done       <= 1'b0;
            o_overflow   <= 1'b0;
          end
        end
        ST_RECV: begin
          if (word_ready) state <= ST_WRITE;
        end
        ST_WRITE: begin
          ptr          <= ptr + 1'b1;
          o_word_count <= o_word_count + 1'b1;
          if (word == HALT_WORD) begin
            state  <= ST_DONE;
            o_done <= 1'b1;
          end else if (ptr == '1) begin
            state      <= ST_DONE;
            o_done     <= 1'b1;
            o_overflow <= 1'b1;
          end else begin
            state <= ST_RECV;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_busy       = accept_en;
  assign o_mem_we     = (state == ST_WRITE);
  assign o_mem_ce     = (state == ST_WRITE) || !o_busy;
  assign o_mem_data   = word;
  assign o_mem_addr   = o_busy ? ptr : i_pc[ADDR_W+1:2];
  assign o_misaligned = !o_busy && (i_pc[1:0] != 2'b00);
  assign unused_pc_hi = ^i_pc[31:ADDR_W+2];

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized self-checking bench for instr_mem_loader against a byte-stream model.
module tb_instr_mem_loader;

  localparam int          AW   = 8;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;
  localparam int          DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic [31:0]   pc;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_data;
  logic          mem_we, mem_ce, busy, done, overflow, misaligned;
  logic [AW:0]   word_count;

  int n_tests = 0;
  int n_fail  = 0;
  logic [39:0] exp_q[$];
  logic [39:0] mon_e;

  always #5 clk = ~clk;

  instr_mem_loader #(.ADDR_W(AW), .HALT_WORD(HALT)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_start      (start),
    .i_rx_data    (rx_data),
    .i_rx_valid   (rx_valid),
    .i_pc         (pc),
    .o_mem_addr   (mem_addr),
    .o_mem_data   (mem_data),
    .o_mem_we     (mem_we),
    .o_mem_ce     (mem_ce),
    .o_busy       (busy),
    .o_done       (done),
    .o_overflow   (overflow),
    .o_misaligned (misaligned),
    .o_word_count (word_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every memory write must match the next expected (addr, data) pair.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 64'(mem_addr), 64'hDEAD);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", 64'(mem_addr), 64'(mon_e[39:32]));
        check("wr_data", 64'(mem_data), 64'(mon_e[31:0]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    rx_data  = $urandom_range(0, 255);
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic push_word(input int addr, input logic [31:0] w);
    exp_q.push_back({addr[7:0], w});
  endtask

  // Reference: split the stream into big-endian words; a load ends at the
  // halt word or once the memory is full. Trailing bytes are ignored.
  task automatic run_load(input logic [7:0] bytes[$], input int max_gap, input string tag);
    int n_words = 0;
    logic [31:0] w;
    logic halted = 1'b0;
    logic ovf = 1'b0;
    for (int k = 0; k + 3 < bytes.size() && !halted && !ovf; k += 4) begin
      w = {bytes[k], bytes[k+1], bytes[k+2], bytes[k+3]};
      push_word(n_words, w);
      n_words++;
      if (w == HALT) halted = 1'b1;
      else if (n_words == DEPTH) ovf = 1'b1;
    end
    pulse_start();
    foreach (bytes[k]) send_byte(bytes[k], $urandom_range(0, max_gap));
    repeat (3) tick();
    check({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_done"}, 64'(done), 64'(halted | ovf));
    check({tag, "_ovf"}, 64'(overflow), 64'(ovf));
    check({tag, "_count"}, 64'(word_count), 64'(n_words));
    check({tag, "_busy"}, 64'(busy), 64'(!(halted | ovf)));
  endtask

  initial begin
    logic [7:0]  q[$];
    logic [31:0] w;
    logic [31:0] pcv;
    int          nw;

    rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = '0; pc = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_ovf", 64'(overflow), 64'd0);
    check("rst_count", 64'(word_count), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_ce", 64'(mem_ce), 64'd1);

    // Idle address mux: fixed corner PCs, then random ones.
    pc = 32'h0;   #1; check("pc0_addr", 64'(mem_addr), 64'h00);
    pc = 32'h4;   #1; check("pc4_addr", 64'(mem_addr), 64'h01);
    pc = 32'h3FC; #1; check("pc3fc_addr", 64'(mem_addr), 64'hFF);
    pc = 32'h6;   #1; check("pc6_addr", 64'(mem_addr), 64'h01);
    check("pc6_misal", 64'(misaligned), 64'd1);
    for (int i = 0; i < 8; i++) begin
      pcv = $urandom;
      pc = pcv; #1;
      check("pc_rand_addr", 64'(mem_addr), 64'((pcv / 4) % DEPTH));
      check("pc_rand_misal", 64'(misaligned), 64'(pcv % 4 != 0));
    end

    // Basic two-word load; pointer exposed on the address port while receiving.
    push_word(0, 32'h2008_0005);
    push_word(1, HALT);
    pulse_start();
    q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    foreach (q[k]) begin
      send_byte(q[k], 2);
      if (k == 4) begin
        check("recv_busy", 64'(busy), 64'd1);
        check("recv_ptr", 64'(mem_addr), 64'd1);
        check("recv_ce", 64'(mem_ce), 64'd0);
        check("recv_we", 64'(mem_we), 64'd0);
      end
    end
    repeat (3) tick();
    check("basic_pending", 64'(exp_q.size()), 64'd0);
    check("basic_done", 64'(done), 64'd1);
    check("basic_count", 64'(word_count), 64'd2);
    check("basic_ovf", 64'(overflow), 64'd0);

    // Bytes in DONE are ignored: no writes, count held.
    repeat (6) send_byte($urandom_range(0, 255), 0);
    tick();
    check("done_rx_count", 64'(word_count), 64'd2);
    check("done_rx_busy", 64'(busy), 64'd0);

    // Byte arriving in the write cycle becomes byte 0 of the next word.
    q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAB, 8'hCD, 8'hEF, 8'h01, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(q, 0, "b2b");

    // Start in RECV after one byte is ignored.
    push_word(0, 32'h1234_5678);
    push_word(1, HALT);
    pulse_start();
    send_byte(8'h12, 1);
    pulse_start();
    check("st_ign_busy", 64'(busy), 64'd1);
    check("st_ign_ptr", 64'(mem_addr), 64'd0);
    q = '{8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    foreach (q[k]) send_byte(q[k], 1);
    repeat (3) tick();
    check("st_ign_pending", 64'(exp_q.size()), 64'd0);
    check("st_ign_count", 64'(word_count), 64'd2);

    // Reset after two bytes: nothing written, then a clean load to addr 0.
    pulse_start();
    send_byte(8'hA5, 0);
    send_byte(8'h5A, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_count", 64'(word_count), 64'd0);
    q = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    run_load(q, 2, "after_abort");

    // Random programs of random length ending in the halt word.
    for (int t = 0; t < 6; t++) begin
      q.delete();
      nw = $urandom_range(1, 12);
      for (int j = 0; j < nw; j++) begin
        w = $urandom;
        if (w == HALT) w = 32'h0;
        q.push_back(w[31:24]); q.push_back(w[23:16]);
        q.push_back(w[15:8]);  q.push_back(w[7:0]);
      end
      repeat (4) q.push_back(8'hFF);
      run_load(q, 3, "rand");
    end

    // Unterminated load: stays busy, nothing marked done.
    q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    run_load(q, 1, "partial");
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();

    // Fill the whole memory without a halt word.
    q.delete();
    for (int j = 0; j < DEPTH; j++) begin
      q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h00); q.push_back(8'h01);
    end
    run_load(q, 1, "overflow");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/instr_mem_loader.md
INSTR_MEM_LOADER -- requirements
Module: instr_mem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, word-address width of the instruction memory (depth 2^ADDR_W words).
REQ-002 Parameter HALT_WORD, default 32'hFFFF_FFFF, end-of-program marker word.
REQ-003 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-004 i_rst_n  input  1  reset, synchronous, active-low.
REQ-005 i_start  input  1  one-cycle pulse; begins a program load.
REQ-006 i_rx_data  input  8  received byte from the serial receiver.
REQ-007 i_rx_valid  input  1  one-cycle strobe; i_rx_data valid.
REQ-008 i_pc  input  32  byte-addressed fetch PC.
REQ-009 o_mem_addr  output  ADDR_W  word address to instruction memory.
REQ-010 o_mem_data  output  32  write data to instruction memory.
REQ-011 o_mem_we  output  1  write enable, one cycle per word.
REQ-012 o_mem_ce  output  1  memory clock enable.
REQ-013 o_busy  output  1  load in progress.
REQ-014 o_done  output  1  sticky; load finished.
REQ-015 o_overflow  output  1  sticky; memory filled before HALT_WORD.
REQ-016 o_misaligned  output  1  i_pc[1:0] != 0 while not busy.
REQ-017 o_word_count  output  ADDR_W+1  words written in current/last load.

Function
REQ-018 FSM states: IDLE, RECV, WRITE, DONE.
REQ-019 IDLE/DONE -> RECV on i_start; entry clears word pointer, byte count, o_word_count, o_done, o_overflow.
REQ-020 i_start in RECV or WRITE shall be ignored.
REQ-021 RECV: each i_rx_valid shifts i_rx_data into the assembly register, first byte = bits [31:24] (big-endian).
REQ-022 RECV -> WRITE in the cycle after the 4th byte is captured; o_mem_data holds the assembled word.
REQ-023 WRITE lasts exactly one cycle: o_mem_we=1, o_mem_addr=word pointer; pointer and o_word_count increment.
REQ-024 WRITE -> DONE if the word equals HALT_WORD (halt word is written), o_done=1.
REQ-025 WRITE -> DONE with o_done=1 and o_overflow=1 if the write targeted address 2^ADDR_W-1 and word != HALT_WORD.
REQ-026 Otherwise WRITE -> RECV.
REQ-027 i_rx_valid during WRITE shall be accepted as byte 0 of the next word, not dropped.
REQ-028 i_rx_valid in IDLE or DONE shall be ignored.
REQ-029 o_busy=1 exactly in RECV and WRITE.
REQ-030 Not busy: o_mem_addr = i_pc[ADDR_W+1:2] (byte-to-word conversion, PC+4 -> next word); combinational.
REQ-031 Busy: o_mem_addr = word pointer.
REQ-032 o_mem_ce = 1 in WRITE and whenever not busy; 0 in RECV.
REQ-033 o_mem_we = 0 in every state except WRITE.

Reset
REQ-034 i_rst_n=0 at a rising edge forces IDLE, pointer=0, byte count=0, assembly register=0, o_done=0, o_overflow=0, o_word_count=0, o_mem_we=0.
REQ-035 Reset mid-load shall abort with no further write; a partially assembled word is discarded.

Structure
REQ-036 Shared package mips_pkg holds ADDR_W default, HALT_WORD default, and the loader state encoding.
REQ-037 Byte-to-word assembly (shift register + 2-bit byte counter, word_ready pulse) is sub-module word_assembler; FSM, pointer and address mux stay in instr_mem_loader.

Verification
REQ-038 Start, bytes 20 08 00 05 FF FF FF FF -> writes addr0=0x2008_0005, addr1=0xFFFF_FFFF; o_done=1, o_word_count=2, o_overflow=0.
REQ-039 Idle, i_pc=0x0/0x4/0x3FC -> o_mem_addr=0x00/0x01/0xFF; i_pc=0x6 -> o_misaligned=1, o_mem_addr=0x01.
REQ-040 ADDR_W=8, 256 words of 0x0000_0001 -> 256 writes, last at 0xFF, o_overflow=1, o_done=1, o_word_count=256.
REQ-041 Reset after 2 bytes -> no write, IDLE; new start plus 4 bytes writes addr0.
REQ-042 i_rx_valid (byte 0xAB) coincident with WRITE -> next word's bits [31:24]=0xAB.
REQ-043 i_start pulsed in RECV after 1 byte -> ignored; pointer and byte count unchanged.
